// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP encoding and
// default reset vector used by the fetch stage.
package mips_pkg;

  localparam int          OPCODE_W         = 6;
  localparam logic [31:0] NOP_INSTR        = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: request outstanding at pc
  // HOLD : response parked in skid buffer while the hazard unit stalls
  // DRAIN: waiting out a response orphaned by a branch
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. The payload is a flat {valid, instr, pc_plus4}
// vector; a bubble is all zeros (valid 0, NOP instr 0, pc_plus4 0).
// flush beats load; neither asserted holds the current contents.
module if_id_reg #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // bubble on reset/flush, capture on load, otherwise hold
  always_ff @(posedge clk) begin
    if (reset || flush) r_q <= '0;
    else if (load)      r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, req/ready imem port, skid buffer for
// stalled responses, branch redirect/flush and the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / bubble_count.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic [DATA_W-1:0]   imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic                if_id_valid,
  output logic [DATA_W-1:0]   if_id_instr,
  output logic [ADDR_W-1:0]   if_id_pc_plus4,
  output logic [OPCODE_W-1:0] if_id_opcode
`ifdef FETCH_PERF_CNT_EN
  , output logic [31:0]       fetch_count
  , output logic [31:0]       bubble_count
`endif
);

  localparam int IFW = 1 + DATA_W + ADDR_W;

  fetch_state_t      r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic              r_req;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_drain_addr;

  logic              w_load, w_flush, w_buf_cap, w_drain_cap;
  logic [IFW-1:0]    w_d, w_q;
  logic [ADDR_W-1:0] w_pc_plus4, w_target;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_target   = branch_target & ~ADDR_W'(3);

  // DRAIN keeps presenting the orphaned address until its response lands
  assign imem_req  = r_req;
  assign imem_addr = (r_state == DRAIN) ? r_drain_addr : (r_pc & ~ADDR_W'(3));

  // next-state / IF/ID control; branch overrides stall and everything else
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_buf_cap    = 1'b0;
    w_drain_cap  = 1'b0;
    w_d          = {1'b1, imem_rdata, w_pc_plus4};
    if (branch_taken) begin
      w_flush   = 1'b1;
      w_pc_next = w_target;
      case (r_state)
        FETCH: begin
          if (r_req && !imem_ready) begin
            w_next_state = DRAIN;
            w_drain_cap  = 1'b1;
          end else begin
            w_next_state = FETCH;
          end
        end
        DRAIN:   w_next_state = imem_ready ? FETCH : DRAIN;
        default: w_next_state = FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          // r_req low only in the first cycle out of reset: nothing in flight
          if (r_req) begin
            if (imem_ready && !stall) begin
              w_load    = 1'b1;
              w_pc_next = w_pc_plus4;
            end else if (imem_ready) begin
              w_buf_cap    = 1'b1;
              w_next_state = HOLD;
            end else if (!stall) begin
              w_flush = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            w_load       = 1'b1;
            w_d          = {1'b1, r_buf, w_pc_plus4};
            w_pc_next    = w_pc_plus4;
            w_next_state = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) w_next_state = FETCH;
        end
        default: w_next_state = FETCH;
      endcase
    end
  end

  // PC, FSM, registered request and skid/drain capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_buf        <= NOP_INSTR[DATA_W-1:0];
      r_drain_addr <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_req   <= (w_next_state != HOLD);
      if (w_buf_cap)   r_buf        <= imem_rdata;
      if (w_drain_cap) r_drain_addr <= imem_addr;
    end
  end

  if_id_reg #(.W(IFW)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .flush (w_flush),
    .d     (w_d),
    .q     (w_q)
  );

  assign if_id_valid    = w_q[IFW-1];
  assign if_id_instr    = w_q[ADDR_W +: DATA_W];
  assign if_id_pc_plus4 = w_q[ADDR_W-1:0];
  assign if_id_opcode   = if_id_instr[DATA_W-1 -: OPCODE_W];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;

  // every valid load is a fetch; every bubble load (incl. flush) is a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_flush)     r_bubble_cnt <= r_bubble_cnt + 32'd1;
      else if (w_load) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_count  = r_fetch_cnt;
  assign bubble_count = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Accepted memory responses are pushed
// to a scoreboard and popped as they appear in IF/ID; directed tasks add
// cycle-exact checks on addresses, request and IF/ID contents.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  if_id_opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc4[$];
  bit          drop_pending = 0;
  int          exp_fetch = 0;
  int          exp_bubble = 0;

  always #5 clk = ~clk;

  // memory image: opcode field varies with the address so it gets exercised
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[7:2], a[25:0]};
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_opcode   (if_id_opcode)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count  (fetch_count)
    , .bubble_count (bubble_count)
`endif
  );

  // one clock: drive at negedge, update scoreboard, check at next negedge
  task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic rdy);
    logic        acc;
    logic [31:0] a, ei, ep;
    stall = s; branch_taken = b; branch_target = t; imem_ready = rdy;
    a   = imem_addr;
    acc = imem_req && rdy && !b;
    if (b || (imem_req && !drop_pending && !rdy && !s)) exp_bubble++;
    if (imem_req && rdy && drop_pending) begin acc = 0; drop_pending = 0; end
    if (b) begin
      q_instr.delete(); q_pc4.delete();
      if (imem_req && !rdy) drop_pending = 1;
    end
    if (acc) begin q_instr.push_back(mem_f(a)); q_pc4.push_back(a + 32'd4); end
    @(posedge clk); @(negedge clk);
    if (b) begin
      n_chk++;
      if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", if_id_valid); end
    end else if (!s) begin
      if (if_id_valid === 1'b1) begin
        exp_fetch++;
        n_chk++;
        if (q_instr.size() == 0) begin
          n_fail++; $display("FAIL sb_unexpected: instr %h pc4 %h with empty scoreboard", if_id_instr, if_id_pc_plus4);
        end else begin
          ei = q_instr.pop_front(); ep = q_pc4.pop_front();
          if (if_id_instr !== ei || if_id_pc_plus4 !== ep || if_id_opcode !== ei[31:26]) begin
            n_fail++;
            $display("FAIL sb_data: got instr %h pc4 %h op %h want instr %h pc4 %h op %h",
                     if_id_instr, if_id_pc_plus4, if_id_opcode, ei, ep, ei[31:26]);
          end
        end
      end
      n_chk++;
      if (q_instr.size() != 0) begin n_fail++; $display("FAIL sb_lost: %0d accepted instrs not delivered", q_instr.size()); end
    end
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; branch_taken = 0; branch_target = 0; imem_ready = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (imem_req !== 0 || if_id_valid !== 0 || if_id_instr !== 0 || if_id_pc_plus4 !== 0 ||
        if_id_opcode !== 0 || imem_addr !== 0) begin
      n_fail++;
      $display("FAIL reset_state: req %b valid %b instr %h pc4 %h op %h addr %h want all 0",
               imem_req, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_opcode, imem_addr);
    end
    reset = 0;
    n_chk++;
    if (imem_req !== 0) begin n_fail++; $display("FAIL release_req: got %b want 0", imem_req); end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (imem_req !== 1 || imem_addr !== 32'h0 || if_id_valid !== 0) begin
      n_fail++; $display("FAIL first_req: req %b addr %h valid %b want 1 0 0", imem_req, imem_addr, if_id_valid);
    end
  endtask

  task automatic test_stream();
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_valid !== 1 || if_id_pc_plus4 !== 32'h4 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL stream0: valid %b pc4 %h addr %h want 1 4 4", if_id_valid, if_id_pc_plus4, imem_addr);
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_pc_plus4 !== 32'h8 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL stream1: pc4 %h addr %h want 8 8", if_id_pc_plus4, imem_addr);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      n_chk++;
      if (imem_req !== 0 || if_id_valid !== 1 || if_id_pc_plus4 !== 32'h8 || if_id_instr !== mem_f(32'h4)) begin
        n_fail++; $display("FAIL stall_hold%0d: req %b valid %b pc4 %h instr %h want 0 1 8 %h",
                           i, imem_req, if_id_valid, if_id_pc_plus4, if_id_instr, mem_f(32'h4));
      end
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_pc_plus4 !== 32'hC || if_id_instr !== mem_f(32'h8) || imem_addr !== 32'hC || imem_req !== 1) begin
      n_fail++; $display("FAIL stall_release: pc4 %h instr %h addr %h req %b want C %h C 1",
                         if_id_pc_plus4, if_id_instr, imem_addr, imem_req, mem_f(32'h8));
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_pc_plus4 !== 32'h10 || imem_addr !== 32'h10) begin
      n_fail++; $display("FAIL stall_resume: pc4 %h addr %h want 10 10", if_id_pc_plus4, imem_addr);
    end
  endtask

  task automatic test_not_ready();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0);
      n_chk++;
      if (if_id_valid !== 0 || if_id_instr !== 0 || imem_addr !== 32'h10 || imem_req !== 1) begin
        n_fail++; $display("FAIL wait_bubble%0d: valid %b instr %h addr %h req %b want 0 0 10 1",
                           i, if_id_valid, if_id_instr, imem_addr, imem_req);
      end
    end
    repeat (4) cyc(0, 0, 0, 1);
    n_chk++;
    if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL wait_resume: addr %h want 20", imem_addr); end
  endtask

  task automatic test_branch_drain();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h103, 0);
    n_chk++;
    if (imem_addr !== 32'h20 || imem_req !== 1) begin
      n_fail++; $display("FAIL drain_addr: addr %h req %b want 20 1", imem_addr, imem_req);
    end
    cyc(0, 0, 0, 0);
    n_chk++;
    if (imem_addr !== 32'h20 || if_id_valid !== 0) begin
      n_fail++; $display("FAIL drain_wait: addr %h valid %b want 20 0", imem_addr, if_id_valid);
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (imem_addr !== 32'h100 || if_id_valid !== 0) begin
      n_fail++; $display("FAIL drain_done: addr %h valid %b want 100 0", imem_addr, if_id_valid);
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL drain_target: pc4 %h want 104", if_id_pc_plus4); end
  endtask

  task automatic test_branch_stall();
    cyc(1, 1, 32'h200, 1);
    n_chk++;
    if (imem_addr !== 32'h200 || imem_req !== 1) begin
      n_fail++; $display("FAIL br_stall: addr %h req %b want 200 1", imem_addr, imem_req);
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL br_stall_next: pc4 %h want 204", if_id_pc_plus4); end
    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h300, 0);
    n_chk++;
    if (imem_addr !== 32'h300 || imem_req !== 1) begin
      n_fail++; $display("FAIL br_hold: addr %h req %b want 300 1", imem_addr, imem_req);
    end
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_pc_plus4 !== 32'h304) begin n_fail++; $display("FAIL br_hold_next: pc4 %h want 304", if_id_pc_plus4); end
  endtask

  task automatic test_wrap();
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 1);
    n_chk++;
    if (if_id_valid !== 1 || if_id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap: valid %b pc4 %h addr %h want 1 0 0", if_id_valid, if_id_pc_plus4, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic s, b, r;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom % 4) == 0;
      b = ($urandom % 16) == 0;
      r = ($urandom % 3) != 0;
      cyc(s, b, $urandom, r);
    end
    repeat (4) cyc(0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_not_ready();
    test_branch_drain();
    test_branch_stall();
    test_wrap();
    test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
    n_chk++;
    if (fetch_count !== 32'(exp_fetch) || bubble_count !== 32'(exp_bubble)) begin
      n_fail++; $display("FAIL perf_cnt: fetch %0d bubble %0d want %0d %0d", fetch_count, bubble_count, exp_fetch, exp_bubble);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
